// File: rtl/clock_bcd_sequencer.sv
// rtl/clock_bcd_sequencer.sv - shares one binary-to-BCD converter across the hours, minutes and seconds fields
// The three fields are captured together and all six digits are committed on one edge.

module bin_to_bcd (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [13:0] shift;

  // Double-dabble: adjust each BCD nibble before every shift.
  always_comb begin
    shift = {8'd0, bin_i};
    for (int i = 0; i < 6; i++) begin
      if (shift[9:6] >= 4'd5) begin
        shift[9:6] = shift[9:6] + 4'd3;
      end
      if (shift[13:10] >= 4'd5) begin
        shift[13:10] = shift[13:10] + 4'd3;
      end
      shift = shift << 1;
    end
    tens_o = shift[13:10];
    ones_o = shift[9:6];
  end

endmodule

module clock_bcd_sequencer #(
  parameter bit BLANK_HOURS_MSB = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_refresh_stb,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  output logic [3:0] o_hours_msb,
  output logic [3:0] o_hours_lsb,
  output logic [3:0] o_minutes_msb,
  output logic [3:0] o_minutes_lsb,
  output logic [3:0] o_seconds_msb,
  output logic [3:0] o_seconds_lsb,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_SEC,
    ST_CONV_MIN,
    ST_CONV_HR,
    ST_DONE
  } state_t;

  localparam logic [3:0] HR_MSB_RST = BLANK_HOURS_MSB ? 4'hF : 4'h0;

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [4:0] snap_hr_q, snap_hr_d;
  logic [5:0] snap_min_q, snap_min_d;
  logic [5:0] snap_sec_q, snap_sec_d;
  logic [3:0] stg_sec_tens_q, stg_sec_tens_d;
  logic [3:0] stg_sec_ones_q, stg_sec_ones_d;
  logic [3:0] stg_min_tens_q, stg_min_tens_d;
  logic [3:0] stg_min_ones_q, stg_min_ones_d;
  logic [3:0] hr_msb_q, hr_msb_d;
  logic [3:0] hr_lsb_q, hr_lsb_d;
  logic [3:0] min_msb_q, min_msb_d;
  logic [3:0] min_lsb_q, min_lsb_d;
  logic [3:0] sec_msb_q, sec_msb_d;
  logic [3:0] sec_lsb_q, sec_lsb_d;

  logic [5:0] conv_bin;
  logic [3:0] conv_tens;
  logic [3:0] conv_ones;
  logic       take_snap;

  // The state register doubles as the converter's registered mux select.
  always_comb begin
    conv_bin = 6'd0;
    case (state_q)
      ST_CONV_SEC: conv_bin = snap_sec_q;
      ST_CONV_MIN: conv_bin = snap_min_q;
      ST_CONV_HR:  conv_bin = {1'b0, snap_hr_q};
      default:     conv_bin = 6'd0;
    endcase
  end

  bin_to_bcd u_bin_to_bcd (
    .bin_i  (conv_bin),
    .tens_o (conv_tens),
    .ones_o (conv_ones)
  );

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    take_snap      = 1'b0;
    stg_sec_tens_d = stg_sec_tens_q;
    stg_sec_ones_d = stg_sec_ones_q;
    stg_min_tens_d = stg_min_tens_q;
    stg_min_ones_d = stg_min_ones_q;
    hr_msb_d       = hr_msb_q;
    hr_lsb_d       = hr_lsb_q;
    min_msb_d      = min_msb_q;
    min_lsb_d      = min_lsb_q;
    sec_msb_d      = sec_msb_q;
    sec_lsb_d      = sec_lsb_q;

    case (state_q)
      ST_IDLE: begin
        if (i_refresh_stb) begin
          take_snap = 1'b1;
          state_d   = ST_CONV_SEC;
        end
      end
      ST_CONV_SEC: begin
        stg_sec_tens_d = conv_tens;
        stg_sec_ones_d = conv_ones;
        if (i_refresh_stb) pending_d = 1'b1;
        state_d = ST_CONV_MIN;
      end
      ST_CONV_MIN: begin
        stg_min_tens_d = conv_tens;
        stg_min_ones_d = conv_ones;
        if (i_refresh_stb) pending_d = 1'b1;
        state_d = ST_CONV_HR;
      end
      ST_CONV_HR: begin
        sec_msb_d = stg_sec_tens_q;
        sec_lsb_d = stg_sec_ones_q;
        min_msb_d = stg_min_tens_q;
        min_lsb_d = stg_min_ones_q;
        hr_msb_d  = (BLANK_HOURS_MSB && conv_tens == 4'd0) ? 4'hF : conv_tens;
        hr_lsb_d  = conv_ones;
        if (i_refresh_stb) pending_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (pending_q || i_refresh_stb) begin
          take_snap = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_CONV_SEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    snap_hr_d  = take_snap ? i_hours   : snap_hr_q;
    snap_min_d = take_snap ? i_minutes : snap_min_q;
    snap_sec_d = take_snap ? i_seconds : snap_sec_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      snap_hr_q      <= 5'd0;
      snap_min_q     <= 6'd0;
      snap_sec_q     <= 6'd0;
      stg_sec_tens_q <= 4'd0;
      stg_sec_ones_q <= 4'd0;
      stg_min_tens_q <= 4'd0;
      stg_min_ones_q <= 4'd0;
      hr_msb_q       <= HR_MSB_RST;
      hr_lsb_q       <= 4'd0;
      min_msb_q      <= 4'd0;
      min_lsb_q      <= 4'd0;
      sec_msb_q      <= 4'd0;
      sec_lsb_q      <= 4'd0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      snap_hr_q      <= snap_hr_d;
      snap_min_q     <= snap_min_d;
      snap_sec_q     <= snap_sec_d;
      stg_sec_tens_q <= stg_sec_tens_d;
      stg_sec_ones_q <= stg_sec_ones_d;
      stg_min_tens_q <= stg_min_tens_d;
      stg_min_ones_q <= stg_min_ones_d;
      hr_msb_q       <= hr_msb_d;
      hr_lsb_q       <= hr_lsb_d;
      min_msb_q      <= min_msb_d;
      min_lsb_q      <= min_lsb_d;
      sec_msb_q      <= sec_msb_d;
      sec_lsb_q      <= sec_lsb_d;
    end
  end

  assign o_hours_msb   = hr_msb_q;
  assign o_hours_lsb   = hr_lsb_q;
  assign o_minutes_msb = min_msb_q;
  assign o_minutes_lsb = min_lsb_q;
  assign o_seconds_msb = sec_msb_q;
  assign o_seconds_lsb = sec_lsb_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_clock_bcd_sequencer.sv
// tb/tb_clock_bcd_sequencer.sv - randomized bench for clock_bcd_sequencer against a timing-rule reference model
// Drives two instances (blanking off and on) with identical stimulus.

module tb_clock_bcd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       stb;
  logic [4:0] hrs;
  logic [5:0] mins;
  logic [5:0] secs;

  logic [3:0] a_hm, a_hl, a_mm, a_ml, a_sm, a_sl;
  logic       a_busy, a_done;
  logic [3:0] b_hm, b_hl, b_mm, b_ml, b_sm, b_sl;
  logic       b_busy, b_done;

  clock_bcd_sequencer #(.BLANK_HOURS_MSB(1'b0)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_refresh_stb(stb),
    .i_hours(hrs), .i_minutes(mins), .i_seconds(secs),
    .o_hours_msb(a_hm), .o_hours_lsb(a_hl),
    .o_minutes_msb(a_mm), .o_minutes_lsb(a_ml),
    .o_seconds_msb(a_sm), .o_seconds_lsb(a_sl),
    .o_busy(a_busy), .o_done(a_done)
  );

  clock_bcd_sequencer #(.BLANK_HOURS_MSB(1'b1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_refresh_stb(stb),
    .i_hours(hrs), .i_minutes(mins), .i_seconds(secs),
    .o_hours_msb(b_hm), .o_hours_lsb(b_hl),
    .o_minutes_msb(b_mm), .o_minutes_lsb(b_ml),
    .o_seconds_msb(b_sm), .o_seconds_lsb(b_sl),
    .o_busy(b_busy), .o_done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a sequence started at edge k commits at k+3 and its done cycle ends at k+4.
  int edge_n     = 0;
  int start_edge = 0;
  bit active     = 1'b0;
  bit pending    = 1'b0;
  int snap_h, snap_m, snap_s;
  int exp_h      = 0;
  int exp_m      = 0;
  int exp_s      = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_start(input int h, input int m, input int s);
    active     = 1'b1;
    start_edge = edge_n;
    snap_h     = h;
    snap_m     = m;
    snap_s     = s;
  endtask

  task automatic model_edge(input bit r, input bit s, input int h, input int m, input int sc);
    int age;
    edge_n++;
    if (r) begin
      active  = 1'b0;
      pending = 1'b0;
      exp_h   = 0;
      exp_m   = 0;
      exp_s   = 0;
    end else if (!active) begin
      if (s) model_start(h, m, sc);
    end else begin
      age = edge_n - start_edge;
      if (age <= 3 && s) pending = 1'b1;
      if (age == 3) begin
        exp_h = snap_h;
        exp_m = snap_m;
        exp_s = snap_s;
      end else if (age >= 4) begin
        if (pending || s) begin
          model_start(h, m, sc);
          pending = 1'b0;
        end else begin
          active = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_done;
    int hm_blank;
    exp_done = active && (edge_n - start_edge == 3);
    hm_blank = (exp_h / 10 == 0) ? 15 : exp_h / 10;
    chk("busy",        int'(a_busy), int'(active));
    chk("done",        int'(a_done), int'(exp_done));
    chk("hr_msb",      int'(a_hm),   exp_h / 10);
    chk("hr_lsb",      int'(a_hl),   exp_h % 10);
    chk("min_msb",     int'(a_mm),   exp_m / 10);
    chk("min_lsb",     int'(a_ml),   exp_m % 10);
    chk("sec_msb",     int'(a_sm),   exp_s / 10);
    chk("sec_lsb",     int'(a_sl),   exp_s % 10);
    chk("blk_busy",    int'(b_busy), int'(active));
    chk("blk_done",    int'(b_done), int'(exp_done));
    chk("blk_hr_msb",  int'(b_hm),   hm_blank);
    chk("blk_hr_lsb",  int'(b_hl),   exp_h % 10);
    chk("blk_min_msb", int'(b_mm),   exp_m / 10);
    chk("blk_min_lsb", int'(b_ml),   exp_m % 10);
    chk("blk_sec_msb", int'(b_sm),   exp_s / 10);
    chk("blk_sec_lsb", int'(b_sl),   exp_s % 10);
  endtask

  task automatic step(input bit r, input bit s, input int h, input int m, input int sc);
    rst  = r;
    stb  = s;
    hrs  = h[4:0];
    mins = m[5:0];
    secs = sc[5:0];
    @(posedge clk);
    model_edge(r, s, h, m, sc);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'(hrs), int'(mins), int'(secs));
  endtask

  initial begin
    rst  = 1'b1;
    stb  = 1'b0;
    hrs  = 5'd0;
    mins = 6'd0;
    secs = 6'd0;

    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(2);

    step(1'b0, 1'b1, 12, 34, 56);
    idle(5);

    step(1'b0, 1'b1, 9, 5, 0);
    step(1'b0, 1'b0, 23, 59, 59);
    idle(5);

    step(1'b0, 1'b1, 10, 0, 0);
    idle(5);

    step(1'b0, 1'b1, 1, 2, 3);
    step(1'b0, 1'b1, 4, 5, 6);
    step(1'b0, 1'b1, 7, 8, 9);
    step(1'b0, 1'b1, 11, 22, 33);
    step(1'b0, 1'b0, 21, 43, 57);
    step(1'b0, 1'b0, 2, 2, 2);
    idle(6);

    step(1'b0, 1'b1, 31, 63, 60);
    idle(5);

    step(1'b0, 1'b1, 19, 48, 27);
    idle(2);
    step(1'b1, 1'b0, 19, 48, 27);
    idle(3);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end
    idle(5);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
